// File: rtl/reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reset_sequencer : releases three reset domains in order 0,1,2, waiting for
//                   each stage's ready ack, with ack timeout and soft reset
// Revision        : 1.0
// ----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_GAP   = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_rst_req,
  input  logic [2:0] stage_ready,
  output logic [2:0] rst_out_n,
  output logic       seq_done,
  output logic       seq_err,
  output logic [1:0] err_stage
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(STAGE_GAP - 1);
  localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_WAIT_ACK = 3'd1,
    S_GAP      = 3'd2,
    S_DONE     = 3'd3,
    S_ERR      = 3'd4
  } state_t;

  logic [1:0] sync_q;
  logic       rst_sync_n;

  state_t     state_q,     state_d;
  logic [7:0] cnt_q,       cnt_d;
  logic [1:0] idx_q,       idx_d;
  logic [2:0] rst_out_q,   rst_out_d;
  logic       done_q,      done_d;
  logic       err_q,       err_d;
  logic [1:0] err_stage_q, err_stage_d;

  assign rst_sync_n = sync_q[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rst_out_d   = rst_out_q;
    done_d      = done_q;
    err_d       = err_q;
    err_stage_d = err_stage_q;

    // Soft reset shares the cleared state with the unsynchronized-reset window
    if (!rst_sync_n || sw_rst_req) begin
      state_d     = S_HOLD;
      cnt_d       = 8'd0;
      idx_d       = 2'd0;
      rst_out_d   = 3'b000;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_stage_d = 2'd0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_out_d[0] = 1'b1;
            idx_d        = 2'd0;
            cnt_d        = 8'd0;
            state_d      = S_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_WAIT_ACK: begin
          // A ready arriving on the timeout cycle still counts as an ack
          if (stage_ready[idx_q]) begin
            cnt_d = 8'd0;
            if (idx_q == 2'd2) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end else if (cnt_q == ACK_LAST) begin
            state_d     = S_ERR;
            err_d       = 1'b1;
            err_stage_d = idx_q;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            rst_out_d[idx_q + 2'd1] = 1'b1;
            idx_d                   = idx_q + 2'd1;
            cnt_d                   = 8'd0;
            state_d                 = S_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_DONE, S_ERR: begin
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b00;
      state_q     <= S_HOLD;
      cnt_q       <= 8'd0;
      idx_q       <= 2'd0;
      rst_out_q   <= 3'b000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_stage_q <= 2'd0;
    end else begin
      sync_q      <= {sync_q[0], 1'b1};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_out_q   <= rst_out_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign rst_out_n = rst_out_q;
  assign seq_done  = done_q;
  assign seq_err   = err_q;
  assign err_stage = err_stage_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reset_sequencer : scoreboard bench with a timestamp-based reference model
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int HOLD = 3;
  localparam int GAP  = 4;
  localparam int TMO  = 5;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       sw_rst_req  = 1'b0;
  logic [2:0] stage_ready = 3'b000;
  logic [2:0] rst_out_n;
  logic       seq_done;
  logic       seq_err;
  logic [1:0] err_stage;

  reset_sequencer #(
    .HOLD_CYCLES (HOLD),
    .STAGE_GAP   (GAP),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_rst_req  (sw_rst_req),
    .stage_ready (stage_ready),
    .rst_out_n   (rst_out_n),
    .seq_done    (seq_done),
    .seq_err     (seq_err),
    .err_stage   (err_stage)
  );

  always #5 clk = ~clk;

  logic [6:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: edge timestamps of each release/ack, -1 when not yet seen
  int m_edge  = 0;
  int m_sync  = 0;
  int m_start = -1;
  int m_rel[3];
  int m_ack[3];
  bit m_done  = 1'b0;
  bit m_err   = 1'b0;
  int m_err_k = 0;

  task automatic m_clear();
    m_start = -1;
    for (int i = 0; i < 3; i++) begin
      m_rel[i] = -1;
      m_ack[i] = -1;
    end
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_err_k = 0;
  endtask

  task automatic model_edge(input logic rn, input logic sw, input logic [2:0] rdy,
                            output logic [6:0] ex);
    int   k;
    logic live;
    m_edge++;
    if (!rn) begin
      m_sync = 0;
      m_clear();
    end else begin
      live = (m_sync >= 2);
      if (m_sync < 2) m_sync++;
      if (!live || sw) begin
        m_clear();
      end else begin
        if (m_start < 0) m_start = m_edge;
        k = (m_rel[2] >= 0) ? 2 : (m_rel[1] >= 0) ? 1 : (m_rel[0] >= 0) ? 0 : -1;
        if (k < 0) begin
          if (m_edge == m_start + HOLD - 1) m_rel[0] = m_edge;
        end else if (m_ack[k] < 0) begin
          if (!m_err) begin
            if (rdy[k]) begin
              m_ack[k] = m_edge;
              if (k == 2) m_done = 1'b1;
            end else if (m_edge == m_rel[k] + 1 + TMO) begin
              m_err   = 1'b1;
              m_err_k = k;
            end
          end
        end else if (k < 2 && m_edge == m_ack[k] + GAP) begin
          m_rel[k+1] = m_edge;
        end
      end
    end
    ex = {m_rel[2] >= 0, m_rel[1] >= 0, m_rel[0] >= 0, m_done, m_err,
          m_err ? 2'(m_err_k) : 2'd0};
  endtask

  // One clock of stimulus; an asynchronous assertion also queues an immediate check
  task automatic cycle(input logic rn, input logic sw, input logic [2:0] rdy);
    logic [6:0] ex;
    @(negedge clk);
    #2;
    if (rst_n && !rn) exp_q.push_back(7'd0);
    rst_n       = rn;
    sw_rst_req  = sw;
    stage_ready = rdy;
    model_edge(rn, sw, rdy, ex);
    exp_q.push_back(ex);
  endtask

  task automatic check_outputs();
    logic [6:0] ex;
    logic [6:0] got;
    n_checks++;
    got = {rst_out_n, seq_done, seq_err, err_stage};
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty t=%0t got %b, no expected entry queued", $time, got);
    end else begin
      ex = exp_q.pop_front();
      if (got === ex) begin
        n_pass++;
      end else begin
        $display("FAIL outputs t=%0t got rst_out_n=%b seq_done=%b seq_err=%b err_stage=%0d, expected rst_out_n=%b seq_done=%b seq_err=%b err_stage=%0d",
                 $time, got[6:4], got[3], got[2], got[1:0], ex[6:4], ex[3], ex[2], ex[1:0]);
      end
    end
  endtask

  initial begin
    #3;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      check_outputs();
    end
  end

  initial begin
    logic [6:0] ex;
    logic       rn;
    logic       sw;
    logic [2:0] rdy;
    int         ne;

    model_edge(1'b0, 1'b0, 3'b000, ex);
    exp_q.push_back(ex);
    repeat (3) cycle(1'b0, 1'b0, 3'b000);

    // Clean sequence to DONE, then a soft reset replay
    repeat (40) cycle(1'b1, 1'b0, 3'b111);
    cycle(1'b1, 1'b1, 3'b111);
    repeat (30) cycle(1'b1, 1'b0, 3'b111);

    // Stage 0 timeout, then ready toggling while in ERR
    cycle(1'b1, 1'b1, 3'b000);
    repeat (HOLD + TMO + 4) cycle(1'b1, 1'b0, 3'b000);
    repeat (12) cycle(1'b1, 1'b0, 3'($urandom_range(0, 7)));

    // Stage 1 never acks
    cycle(1'b1, 1'b1, 3'b000);
    repeat (40) cycle(1'b1, 1'b0, 3'b101);

    // Every ack lands exactly on the timeout edge
    cycle(1'b1, 1'b1, 3'b000);
    for (int i = 0; i < 40; i++) begin
      ne  = m_edge + 1;
      rdy = 3'b000;
      for (int s = 0; s < 3; s++)
        if (m_rel[s] >= 0 && m_ack[s] < 0 && ne == m_rel[s] + 1 + TMO) rdy[s] = 1'b1;
      cycle(1'b1, 1'b0, rdy);
    end

    // Asynchronous reset in the gap between stages 1 and 2
    cycle(1'b1, 1'b1, 3'b111);
    for (int i = 0; i < 60; i++) begin
      if (m_ack[1] >= 0 && m_rel[2] < 0) break;
      cycle(1'b1, 1'b0, 3'b111);
    end
    repeat (2) cycle(1'b0, 1'b0, 3'b111);
    repeat (30) cycle(1'b1, 1'b0, 3'b111);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rn  = rst_n ? ($urandom_range(0, 120) != 0) : ($urandom_range(0, 2) == 0);
      sw  = ($urandom_range(0, 60) == 0);
      rdy = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0)};
      cycle(rn, sw, rdy);
    end

    cycle(1'b1, 1'b0, 3'b000);
    @(negedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, meaning cycles all stages stay in reset after synchronized release (legal 1..255).
REQ-002 SHALL have parameter STAGE_GAP, default 8, meaning cycles from a stage's ready acceptance to the next stage's release (legal 1..255).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255, meaning max wait cycles for stage_ready before error (legal 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port sw_rst_req  input  1  synchronous soft-reset request, active-high, sampled every edge.
REQ-007 SHALL have port stage_ready  input  3  per-stage "out of reset and ready" ack, bit i for stage i.
REQ-008 SHALL have port rst_out_n  output  3  registered active-low reset to stage i, released in order 0,1,2.
REQ-009 SHALL have port seq_done  output  1  registered; high when all three stages released and acknowledged.
REQ-010 SHALL have port seq_err  output  1  registered; high when a stage ack timed out.
REQ-011 SHALL have port err_stage  output  2  registered; index of the timed-out stage, valid while seq_err=1.

Function
REQ-012 SHALL synchronize rst_n deassertion with a 2-flop chain (both flops async-cleared by rst_n); rst_sync_n = second flop.
REQ-013 SHALL hold the FSM in HOLD with counters cleared while rst_sync_n=0.
REQ-014 SHALL implement states HOLD, WAIT_ACK, GAP, DONE, ERR, with an 8-bit cycle counter cnt and 2-bit stage index idx.
REQ-015 HOLD: cnt increments each edge with rst_sync_n=1; on an edge with cnt==HOLD_CYCLES-1 set rst_out_n[0]=1, idx=0, cnt=0, go WAIT_ACK.
REQ-016 WAIT_ACK: if stage_ready[idx]=1, go DONE if idx==2, else GAP with cnt=0; ready beats timeout in the same cycle.
REQ-017 WAIT_ACK: if stage_ready[idx]=0 and cnt==ACK_TIMEOUT, go ERR, set seq_err=1, err_stage=idx; otherwise cnt increments.
REQ-018 GAP: cnt increments; on an edge with cnt==STAGE_GAP-1 set rst_out_n[idx+1]=1, idx=idx+1, cnt=0, go WAIT_ACK.
REQ-019 DONE: seq_done=1; state, rst_out_n held until rst_n or sw_rst_req.
REQ-020 ERR: already-released stages stay released, unreleased stay in reset; seq_err/err_stage held until rst_n or sw_rst_req.
REQ-021 Only stage_ready[idx] SHALL be observed, and only in WAIT_ACK; other bits are ignored.
REQ-022 sw_rst_req=1 on any edge with rst_sync_n=1 SHALL, at that edge: rst_out_n=3'b000, seq_done=0, seq_err=0, err_stage=0, cnt=0, idx=0, state HOLD; it overrides all other transitions.
REQ-023 sw_rst_req held high SHALL keep the block in HOLD with cnt=0; counting starts on the first edge it is low.
REQ-024 A released bit of rst_out_n SHALL never return to 0 except via rst_n or sw_rst_req.
REQ-025 Counter compares SHALL be exact equality on 8 bits; cnt never wraps since every terminal value exits the state.

Reset
REQ-026 rst_n=0 SHALL asynchronously force rst_out_n=3'b000, seq_done=0, seq_err=0, err_stage=0, cnt=0, idx=0, state HOLD, sync flops 0, regardless of clk.
REQ-027 rst_n assertion mid-sequence (any state) SHALL take effect immediately, and the full sequence restarts after synchronized release.

Verification
REQ-028 Defaults, stage_ready tied 3'b111; rst_n rises before edge 1 -> rst_out_n[0] rises at edge 6, [1] at edge 15, [2] at edge 24, seq_done=1 at edge 25.
REQ-029 Defaults; stage_ready[1] held 0 -> rst_out_n=3'b011 from edge 15; seq_err=1, err_stage=1 at edge 271; rst_out_n[2] stays 0.
REQ-030 In DONE, pulse sw_rst_req one cycle -> rst_out_n=3'b000, seq_done=0 on that edge; sequence replays with [0] released 4 edges later.
REQ-031 Assert rst_n low asynchronously during GAP between stages 1 and 2 -> rst_out_n=3'b000 before next clk edge; after release, sequence restarts from stage 0.
REQ-032 ACK_TIMEOUT=3, stage_ready[0] rises on the same edge cnt==3 -> ready wins, GAP entered, seq_err stays 0.
REQ-033 In ERR (stage 0 timeout), toggle stage_ready and hold sw_rst_req 0 -> no output change; sw_rst_req pulse clears seq_err and restarts.
